i2c2_readback: RTL and testbench

Register read-back sequencer for the I2C2 bus: on a single-cycle request it drives the I2C master command/data streams to write a register pointer to a device, then reads 1–4 bytes back with a repeated start. It returns the bytes as one right-aligned 32-bit word with a valid strobe. It is the read-direction companion to the I2C2 init/write block and shares the same I2C master through the existing bus arbitration.

---
 rtl/i2c2_pkg.sv | 27 ++
 rtl/i2c2_readback_if.sv | 45 ++++
 rtl/i2c2_readback.sv | 165 ++++++++++++++++
 tb/tb_i2c2_readback.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c2_pkg.sv
`default_nettype none
// ============================================================================
// i2c2_pkg : shared state encoding, length helper and watchdog default
// Rev 1.0
// ============================================================================
package i2c2_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PTR_CMD  = 3'd1,
      S_PTR_DATA = 3'd2,
      S_RD_CMD   = 3'd3,
      S_RD_DATA  = 3'd4,
      S_DONE     = 3'd5,
      S_ABORT    = 3'd6
   } i2c2_rb_state_t;

   // Also intended for the i2c2_init watchdog so both blocks abort alike.
   localparam int unsigned c_TIMEOUT_DEFAULT = 65535;

   // Byte count (1..4) to the 2-bit "count minus one" field.
   function automatic logic [1:0] i2c2_len_enc(input int unsigned nbytes);
      return 2'(nbytes - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/i2c2_readback_if.sv
`default_nettype none
// ============================================================================
// i2c2_readback_if : command / data streams between sequencer and I2C master
// Rev 1.0
// ============================================================================
interface i2c2_readback_if;
   import i2c2_pkg::*;

   logic [6:0] cmd_address;
   logic       cmd_start;
   logic       cmd_read;
   logic       cmd_write;
   logic       cmd_write_multiple;
   logic       cmd_stop;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       data_out_ready;
   logic       data_out_last;
   logic [7:0] data_in;
   logic       data_in_valid;
   logic       data_in_ready;
   logic       data_in_last;
   logic       missed_ack;

   // master: the sequencer issuing commands; slave: the I2C master core
   modport master (
      output cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple,
             cmd_stop, cmd_valid, data_out, data_out_valid, data_out_last,
             data_in_ready,
      input  cmd_ready, data_out_ready, data_in, data_in_valid, data_in_last,
             missed_ack
   );

   modport slave (
      input  cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple,
             cmd_stop, cmd_valid, data_out, data_out_valid, data_out_last,
             data_in_ready,
      output cmd_ready, data_out_ready, data_in, data_in_valid, data_in_last,
             missed_ack
   );

endinterface
`default_nettype wire

// File: rtl/i2c2_readback.sv
`default_nettype none
// ============================================================================
// i2c2_readback : pointer write, repeated-start read of 1-4 bytes, 32-bit result
// Rev 1.0
// ============================================================================
module i2c2_readback
   import i2c2_pkg::*;
#(
   parameter int unsigned TIMEOUT = c_TIMEOUT_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            read,
   input  logic [6:0]      rd_addr,
   input  logic [7:0]      rd_reg,
   input  logic [1:0]      rd_len,
   i2c2_readback_if.master bus,
   output logic [31:0]     rdata,
   output logic            rdata_valid,
   output logic            rdata_err,
   output logic            busy
);

   localparam logic [15:0] c_WDOG_LIMIT = 16'(TIMEOUT);
   localparam bit          c_WDOG_EN    = (TIMEOUT != 0);

   i2c2_rb_state_t r_state, w_next;
   logic [6:0]  r_addr;
   logic [7:0]  r_reg;
   logic [1:0]  r_len, r_cnt;
   logic [31:0] r_shift, r_rdata, w_shift_next;
   logic [15:0] r_wdog;
   logic        r_err, r_ptr_sent;
   logic        w_waiting, w_timeout, w_last_byte, w_ptr_accept, w_byte_accept;
   logic        w_cmd_valid, w_cmd_start, w_cmd_read, w_cmd_write, w_cmd_stop;
   logic        w_dout_valid, w_din_ready;
   logic        w_unused_last;

   assign w_waiting    = (r_state == S_PTR_CMD) || (r_state == S_PTR_DATA) ||
                         (r_state == S_RD_CMD)  || (r_state == S_RD_DATA);
   assign w_timeout    = c_WDOG_EN && w_waiting && (r_wdog == c_WDOG_LIMIT);
   assign w_last_byte  = (r_cnt == r_len);
   assign w_shift_next = {r_shift[23:0], bus.data_in};
   assign w_unused_last = bus.data_in_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      w_cmd_valid   = 1'b0;
      w_cmd_start   = 1'b0;
      w_cmd_read    = 1'b0;
      w_cmd_write   = 1'b0;
      w_cmd_stop    = 1'b0;
      w_dout_valid  = 1'b0;
      w_din_ready   = 1'b0;
      w_ptr_accept  = 1'b0;
      w_byte_accept = 1'b0;
      case (r_state)
         S_IDLE: if (read) w_next = S_PTR_CMD;
         S_PTR_CMD: begin
            w_cmd_valid  = 1'b1;
            w_cmd_start  = 1'b1;
            w_cmd_write  = 1'b1;
            // The pointer byte may be taken before the command; drop its valid once taken.
            w_dout_valid = !r_ptr_sent;
            w_ptr_accept = !r_ptr_sent && bus.data_out_ready;
            if (bus.cmd_ready)
               w_next = (r_ptr_sent || bus.data_out_ready) ? S_RD_CMD : S_PTR_DATA;
         end
         S_PTR_DATA: begin
            w_dout_valid = 1'b1;
            if (bus.data_out_ready) w_next = S_RD_CMD;
         end
         S_RD_CMD: begin
            w_cmd_valid = 1'b1;
            w_cmd_read  = 1'b1;
            w_cmd_start = (r_cnt == 2'd0);
            w_cmd_stop  = w_last_byte;
            if (bus.cmd_ready) w_next = S_RD_DATA;
         end
         S_RD_DATA: begin
            w_din_ready = 1'b1;
            if (bus.data_in_valid) begin
               w_byte_accept = 1'b1;
               w_next        = w_last_byte ? S_DONE : S_RD_CMD;
            end
         end
         S_DONE:  w_next = S_IDLE;
         S_ABORT: begin
            w_cmd_valid = 1'b1;
            w_cmd_stop  = 1'b1;
            if (bus.cmd_ready) w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
      // Timeout wins over any handshake in the same cycle so nothing is half-accepted.
      if (w_timeout) begin
         w_next        = S_ABORT;
         w_cmd_valid   = 1'b0;
         w_dout_valid  = 1'b0;
         w_din_ready   = 1'b0;
         w_ptr_accept  = 1'b0;
         w_byte_accept = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr     <= '0;
         r_reg      <= '0;
         r_len      <= '0;
         r_cnt      <= '0;
         r_shift    <= '0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
         r_ptr_sent <= 1'b0;
         r_wdog     <= '0;
      end else begin
         if (r_state == S_IDLE) begin
            if (read) begin
               r_addr     <= rd_addr;
               r_reg      <= rd_reg;
               r_len      <= rd_len;
               r_cnt      <= '0;
               r_shift    <= '0;
               r_err      <= 1'b0;
               r_ptr_sent <= 1'b0;
            end
         end else begin
            if (w_ptr_accept) r_ptr_sent <= 1'b1;
            if (w_byte_accept) begin
               r_shift <= w_shift_next;
               if (!w_last_byte) r_cnt <= r_cnt + 2'd1;
            end
            if (bus.missed_ack || w_timeout) r_err <= 1'b1;
         end
         if (w_next == S_DONE) r_rdata <= w_byte_accept ? w_shift_next : r_shift;
         if (w_next != r_state)  r_wdog <= '0;
         else if (w_waiting)     r_wdog <= r_wdog + 16'd1;
      end
   end

   assign bus.cmd_address        = r_addr;
   assign bus.cmd_start          = w_cmd_start;
   assign bus.cmd_read           = w_cmd_read;
   assign bus.cmd_write          = w_cmd_write;
   assign bus.cmd_write_multiple = 1'b0;
   assign bus.cmd_stop           = w_cmd_stop;
   assign bus.cmd_valid          = w_cmd_valid;
   assign bus.data_out           = r_reg;
   assign bus.data_out_valid     = w_dout_valid;
   assign bus.data_out_last      = 1'b1;
   assign bus.data_in_ready      = w_din_ready;

   assign rdata       = r_rdata;
   assign rdata_valid = (r_state == S_DONE);
   assign rdata_err   = (r_state == S_DONE) && r_err;
   assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2c2_readback.sv
`default_nettype none
// tb_i2c2_readback : randomized directed bench with an I2C master responder model
module tb_i2c2_readback;
   import i2c2_pkg::*;

   localparam int unsigned TB_TIMEOUT = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        read;
   logic [6:0]  rd_addr;
   logic [7:0]  rd_reg;
   logic [1:0]  rd_len;
   logic [31:0] rdata;
   logic        rdata_valid, rdata_err, busy;

   i2c2_readback_if bus_if ();

   i2c2_readback #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .read        (read),
      .rd_addr     (rd_addr),
      .rd_reg      (rd_reg),
      .rd_len      (rd_len),
      .bus         (bus_if),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .rdata_err   (rdata_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   bit          bfm_en = 1'b0;
   int          stall_pct = 0;
   time         hold_until = 0;
   logic [7:0]  rsp_q[$];
   logic [10:0] cmd_log[$];
   logic [7:0]  dout_log[$];
   int          stab_err;
   int          rd_pending;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Responder: drives ready/data at negedge, records what will be accepted at the next posedge.
   initial begin : bfm
      logic [10:0] held_cmd, cur;
      logic [7:0]  held_dat;
      bit          cmd_wait, dat_wait, din_hs;
      cmd_wait = 0; dat_wait = 0; din_hs = 0; rd_pending = 0; stab_err = 0;
      held_cmd = '0; held_dat = '0;
      bus_if.cmd_ready = 0; bus_if.data_out_ready = 0; bus_if.data_in = 0;
      bus_if.data_in_valid = 0; bus_if.data_in_last = 0;
      forever begin
         @(negedge clk);
         if (!bfm_en) begin
            bus_if.cmd_ready = 0; bus_if.data_out_ready = 0; bus_if.data_in_valid = 0;
            rsp_q.delete(); rd_pending = 0; cmd_wait = 0; dat_wait = 0; din_hs = 0;
         end else begin
            if (din_hs) begin bus_if.data_in_valid = 0; din_hs = 0; end
            if ($time < hold_until) begin
               bus_if.cmd_ready = 0; bus_if.data_out_ready = 0;
            end else begin
               bus_if.cmd_ready      = ($urandom_range(99) >= stall_pct);
               bus_if.data_out_ready = ($urandom_range(99) >= stall_pct);
            end
            if (!bus_if.data_in_valid && rd_pending > 0 && rsp_q.size() > 0 &&
                $urandom_range(99) >= stall_pct) begin
               bus_if.data_in       = rsp_q.pop_front();
               bus_if.data_in_last  = 1'($urandom_range(1));
               bus_if.data_in_valid = 1;
               rd_pending--;
            end
            #1;
            cur = {bus_if.cmd_start, bus_if.cmd_read, bus_if.cmd_write, bus_if.cmd_stop,
                   bus_if.cmd_address};
            if (bus_if.cmd_valid) begin
               if (cmd_wait && cur != held_cmd) stab_err++;
               if (bus_if.cmd_write_multiple !== 1'b0) stab_err++;
               if (bus_if.cmd_ready) begin
                  cmd_log.push_back(cur);
                  cmd_wait = 0;
                  if (bus_if.cmd_read) rd_pending++;
               end else begin
                  cmd_wait = 1; held_cmd = cur;
               end
            end else begin
               if (cmd_wait) stab_err++;
               cmd_wait = 0;
            end
            if (bus_if.data_out_valid) begin
               if (dat_wait && bus_if.data_out != held_dat) stab_err++;
               if (bus_if.data_out_last !== 1'b1) stab_err++;
               if (bus_if.data_out_ready) begin
                  dout_log.push_back(bus_if.data_out);
                  dat_wait = 0;
               end else begin
                  dat_wait = 1; held_dat = bus_if.data_out;
               end
            end else begin
               if (dat_wait) stab_err++;
               dat_wait = 0;
            end
            if (bus_if.data_in_valid && bus_if.data_in_ready) din_hs = 1;
         end
      end
   end

   // One full request. nsupply < nbytes models a device that stops answering.
   task automatic do_read(input string tag, input logic [6:0] a, input logic [7:0] rg,
                          input int nbytes, input int nsupply, input int stall, input int hold,
                          input bit nak, input bit dup, output logic [31:0] got_data);
      logic [31:0] exp_word;
      logic [10:0] exp_cmds[$];
      bit          timeout_case, exp_err, got, got_err, prev_rdy;
      int          cbase, dbase, sbase, ent_cyc, stop_cyc, nrd;
      while (rsp_q.size() < nsupply) rsp_q.push_back(8'($urandom));
      exp_word = '0;
      for (int i = 0; i < nsupply; i++) exp_word = (exp_word << 8) | 32'(rsp_q[i]);
      timeout_case = (nsupply < nbytes);
      exp_err      = nak || timeout_case;
      cbase = cmd_log.size(); dbase = dout_log.size(); sbase = stab_err;
      stall_pct = stall;
      got_data = '0; got_err = 0; got = 0; prev_rdy = 0; ent_cyc = -1; stop_cyc = -1;

      @(negedge clk);
      read = 1; rd_addr = a; rd_reg = rg; rd_len = i2c2_len_enc(nbytes);
      hold_until = $time + 10 * hold;
      @(negedge clk);
      read = 0; rd_addr = 7'($urandom); rd_reg = 8'($urandom); rd_len = 2'($urandom);
      bus_if.missed_ack = nak;
      chk({tag, ".first_cmd_valid"}, 32'(bus_if.cmd_valid), 32'd1);
      chk({tag, ".busy_rise"}, 32'(busy), 32'd1);

      for (int cyc = 0; cyc < 600 && !got; cyc++) begin
         @(negedge clk);
         bus_if.missed_ack = 0;
         if (dup && cyc == 3) begin read = 1; rd_addr = ~a; rd_reg = ~rg; end
         else read = 0;
         if (bus_if.data_in_ready && !prev_rdy) ent_cyc = cyc;
         prev_rdy = bus_if.data_in_ready;
         if (stop_cyc < 0 && bus_if.cmd_valid && bus_if.cmd_stop && !bus_if.cmd_read)
            stop_cyc = cyc;
         if (rdata_valid) begin got = 1; got_data = rdata; got_err = rdata_err; end
      end
      read = 0;
      chk({tag, ".done_seen"}, 32'(got), 32'd1);
      chk({tag, ".rdata"}, got_data, exp_word);
      chk({tag, ".rdata_err"}, 32'(got_err), 32'(exp_err));
      @(negedge clk);
      chk({tag, ".valid_one_cycle"}, 32'(rdata_valid), 32'd0);
      chk({tag, ".busy_fall"}, 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      chk({tag, ".rdata_hold"}, rdata, exp_word);
      chk({tag, ".no_queued_cmd"}, 32'(bus_if.cmd_valid), 32'd0);

      exp_cmds.push_back({1'b1, 1'b0, 1'b1, 1'b0, a});
      nrd = timeout_case ? nsupply + 1 : nbytes;
      for (int i = 0; i < nrd; i++)
         exp_cmds.push_back({1'(i == 0), 1'b1, 1'b0, 1'(i == nbytes - 1), a});
      if (timeout_case) exp_cmds.push_back({1'b0, 1'b0, 1'b0, 1'b1, a});
      chk({tag, ".ncmds"}, 32'(cmd_log.size() - cbase), 32'(exp_cmds.size()));
      for (int i = 0; i < exp_cmds.size(); i++)
         if (cbase + i < cmd_log.size())
            chk({tag, ".cmd"}, 32'(cmd_log[cbase + i]), 32'(exp_cmds[i]));
      chk({tag, ".nptr"}, 32'(dout_log.size() - dbase), 32'd1);
      if (dout_log.size() > dbase) chk({tag, ".ptr_byte"}, 32'(dout_log[dbase]), 32'(rg));
      chk({tag, ".stable_protocol"}, 32'(stab_err - sbase), 32'd0);
      if (timeout_case)
         chk({tag, ".abort_latency"},
             32'(ent_cyc >= 0 && stop_cyc > ent_cyc && stop_cyc - ent_cyc <= 101), 32'd1);
   endtask

   initial begin : main
      logic [31:0] res_a, res_b;
      logic [7:0]  saved[4];
      bit          seen;
      rst = 1; read = 0; rd_addr = 0; rd_reg = 0; rd_len = 0; bus_if.missed_ack = 0;
      repeat (3) @(negedge clk);
      chk("reset.busy", 32'(busy), 32'd0);
      chk("reset.rdata_valid", 32'(rdata_valid), 32'd0);
      chk("reset.rdata_err", 32'(rdata_err), 32'd0);
      chk("reset.rdata", rdata, 32'd0);
      chk("reset.cmd_valid", 32'(bus_if.cmd_valid), 32'd0);
      chk("reset.dout_valid", 32'(bus_if.data_out_valid), 32'd0);
      chk("reset.din_ready", 32'(bus_if.data_in_ready), 32'd0);
      chk("reset.cmd_address", 32'(bus_if.cmd_address), 32'd0);
      rst = 0; bfm_en = 1;
      repeat (2) @(negedge clk);

      rsp_q.push_back(8'hA5);
      do_read("single", 7'h28, 8'h1C, 1, 1, 0, 0, 0, 0, res_a);
      chk("single.value", res_a, 32'h0000_00A5);

      rsp_q.push_back(8'h11); rsp_q.push_back(8'h22);
      rsp_q.push_back(8'h33); rsp_q.push_back(8'h44);
      do_read("quad_dup", 7'h50, 8'h03, 4, 4, 0, 0, 0, 1, res_a);
      chk("quad.value", res_a, 32'h1122_3344);

      for (int i = 0; i < 4; i++) saved[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) rsp_q.push_back(saved[i]);
      do_read("bp_ref", 7'h3A, 8'h7E, 4, 4, 0, 0, 0, 0, res_a);
      for (int i = 0; i < 4; i++) rsp_q.push_back(saved[i]);
      do_read("bp_stall", 7'h3A, 8'h7E, 4, 4, 50, 20, 0, 0, res_b);
      chk("bp.match", res_b, res_a);

      do_read("nak", 7'h12, 8'hC4, 2, 2, 20, 0, 1, 0, res_a);

      for (int n = 0; n < 4; n++) begin
         int nb;
         nb = 1 + int'($urandom_range(3));
         do_read("rand", 7'($urandom), 8'($urandom), nb, nb, int'($urandom_range(40)), 0, 0, 0, res_a);
      end

      do_read("timeout", 7'h61, 8'h2B, 2, 1, 0, 0, 0, 0, res_a);

      stall_pct = 0;
      @(negedge clk);
      read = 1; rd_addr = 7'h55; rd_reg = 8'h0F; rd_len = i2c2_len_enc(1);
      @(negedge clk);
      read = 0;
      seen = 0;
      for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
         @(negedge clk);
         if (bus_if.data_in_ready) seen = 1;
      end
      chk("arst.reach_rd_data", 32'(seen), 32'd1);
      #3 rst = 1; bfm_en = 0;
      #1;
      chk("arst.busy", 32'(busy), 32'd0);
      chk("arst.din_ready", 32'(bus_if.data_in_ready), 32'd0);
      chk("arst.cmd_valid", 32'(bus_if.cmd_valid), 32'd0);
      chk("arst.dout_valid", 32'(bus_if.data_out_valid), 32'd0);
      chk("arst.rdata_valid", 32'(rdata_valid), 32'd0);
      chk("arst.rdata", rdata, 32'd0);
      chk("arst.cmd_address", 32'(bus_if.cmd_address), 32'd0);
      repeat (2) @(negedge clk);
      rst = 0; bfm_en = 1;
      repeat (2) @(negedge clk);
      chk("arst.idle_after", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
